// File: rtl/rv32i_mem_arbiter.sv
// Arbiter sharing one single-port synchronous unified RAM between the IF fetch port
// and the MEM load/store port, with starvation relief for IF and flush of IF responses.
module rv32i_mem_arbiter #(
    parameter int MEM_ADDR_BITS = 12,
    parameter int MAX_STARVE    = 4
) (
    input  logic                     Clk_100MHz,
    input  logic                     Reset_n,
    input  logic                     Flush,
    input  logic                     IF_req,
    input  logic [31:0]              IF_addr,
    output logic                     IF_gnt,
    output logic                     IF_rvalid,
    output logic [31:0]              IF_rdata,
    input  logic                     MEM_req,
    input  logic                     MEM_we,
    input  logic [3:0]               MEM_be,
    input  logic [31:0]              MEM_addr,
    input  logic [31:0]              MEM_wdata,
    output logic                     MEM_gnt,
    output logic                     MEM_rvalid,
    output logic [31:0]              MEM_rdata,
    output logic                     RAM_en,
    output logic [3:0]               RAM_we,
    output logic [MEM_ADDR_BITS-1:0] RAM_addr,
    output logic [31:0]              RAM_wdata,
    input  logic [31:0]              RAM_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        RESP_IF,
        RESP_MEM
    } resp_e;

    localparam logic [3:0] STARVE_LIMIT = 4'(MAX_STARVE);

    resp_e      state, state_next;
    logic [3:0] starve_cnt;
    logic       if_wins, mem_wins;

    // Word address bits beyond the RAM depth and the byte offset are intentionally dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{IF_addr[31:MEM_ADDR_BITS+2], IF_addr[1:0],
                                MEM_addr[31:MEM_ADDR_BITS+2], MEM_addr[1:0]};

    // Grants are qualified by Reset_n so every output is quiet while reset is held.
    always_comb begin
        if_wins  = Reset_n && IF_req && !Flush && (!MEM_req || starve_cnt == STARVE_LIMIT);
        mem_wins = Reset_n && MEM_req && !if_wins;
    end

    assign IF_gnt  = if_wins;
    assign MEM_gnt = mem_wins;

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        RAM_en    = 1'b0;
        RAM_we    = 4'b0000;
        RAM_addr  = '0;
        RAM_wdata = '0;
        if (if_wins) begin
            RAM_en   = 1'b1;
            RAM_addr = IF_addr[MEM_ADDR_BITS+1:2];
        end else if (mem_wins) begin
            RAM_en    = 1'b1;
            RAM_we    = MEM_we ? MEM_be : 4'b0000;
            RAM_addr  = MEM_addr[MEM_ADDR_BITS+1:2];
            RAM_wdata = MEM_wdata;
        end
    end

    // Counter stops at the limit because IF is then guaranteed the next grant or a clear.
    always_ff @(posedge Clk_100MHz or negedge Reset_n) begin
        if (!Reset_n) begin
            starve_cnt <= 4'd0;
        end else if (IF_req && !Flush && !if_wins) begin
            // NOTE: sequential state uses non-blocking assignments to avoid ordering races.
            starve_cnt <= starve_cnt + 4'd1;
        end else begin
            starve_cnt <= 4'd0;
        end
    end

    always_ff @(posedge Clk_100MHz or negedge Reset_n) begin
        if (!Reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = IDLE;
        if (if_wins)                 state_next = RESP_IF;
        else if (mem_wins && !MEM_we) state_next = RESP_MEM;
    end

    // A flush kills only the IF response; a MEM response in flight is unaffected.
    always_comb begin
        IF_rvalid  = 1'b0;
        IF_rdata   = '0;
        MEM_rvalid = 1'b0;
        MEM_rdata  = '0;
        case (state)
            RESP_IF: begin
                if (!Flush) begin
                    IF_rvalid = 1'b1;
                    IF_rdata  = RAM_rdata;
                end
            end
            RESP_MEM: begin
                MEM_rvalid = 1'b1;
                MEM_rdata  = RAM_rdata;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations plus randomized traffic
// compared every cycle against a transaction-level model of the arbiter and RAM.
module tb_rv32i_mem_arbiter;

    localparam int AW         = 12;
    localparam int MAX_STARVE = 4;
    localparam int DEPTH      = 1 << AW;

    logic          Clk_100MHz = 1'b0;
    logic          Reset_n;
    logic          Flush;
    logic          IF_req;
    logic [31:0]   IF_addr;
    logic          IF_gnt, IF_rvalid;
    logic [31:0]   IF_rdata;
    logic          MEM_req, MEM_we;
    logic [3:0]    MEM_be;
    logic [31:0]   MEM_addr, MEM_wdata;
    logic          MEM_gnt, MEM_rvalid;
    logic [31:0]   MEM_rdata;
    logic          RAM_en;
    logic [3:0]    RAM_we;
    logic [AW-1:0] RAM_addr;
    logic [31:0]   RAM_wdata;
    logic [31:0]   RAM_rdata;

    int n_vec = 0;
    int n_err = 0;

    always #5 Clk_100MHz = ~Clk_100MHz;

    rv32i_mem_arbiter #(.MEM_ADDR_BITS(AW), .MAX_STARVE(MAX_STARVE)) dut (
        .Clk_100MHz(Clk_100MHz), .Reset_n(Reset_n), .Flush(Flush),
        .IF_req(IF_req), .IF_addr(IF_addr), .IF_gnt(IF_gnt),
        .IF_rvalid(IF_rvalid), .IF_rdata(IF_rdata),
        .MEM_req(MEM_req), .MEM_we(MEM_we), .MEM_be(MEM_be),
        .MEM_addr(MEM_addr), .MEM_wdata(MEM_wdata), .MEM_gnt(MEM_gnt),
        .MEM_rvalid(MEM_rvalid), .MEM_rdata(MEM_rdata),
        .RAM_en(RAM_en), .RAM_we(RAM_we), .RAM_addr(RAM_addr),
        .RAM_wdata(RAM_wdata), .RAM_rdata(RAM_rdata)
    );

    function automatic logic [31:0] init_word(int i);
        return {16'hC0DE, 16'(i)};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Synchronous single-port RAM the arbiter drives.
    logic [31:0] ram [DEPTH];
    initial begin
        for (int i = 0; i < DEPTH; i++) ram[i] = init_word(i);
        RAM_rdata = '0;
        forever begin
            @(posedge Clk_100MHz);
            if (RAM_en) begin
                if (RAM_we == 4'b0000) RAM_rdata <= ram[RAM_addr];
                for (int b = 0; b < 4; b++)
                    if (RAM_we[b]) ram[RAM_addr][8*b +: 8] <= RAM_wdata[8*b +: 8];
            end
        end
    end

    // Reference model: who is granted follows from the priority rules and a denial count;
    // each read grant queues the word the shadow memory holds for delivery next cycle.
    logic [31:0] shadow [DEPTH];
    initial begin
        int          denied;
        int          owner;      // 0 none, 1 IF, 2 MEM
        logic [31:0] due_data;
        bit          e_if, e_mem;
        int          widx;
        for (int i = 0; i < DEPTH; i++) shadow[i] = init_word(i);
        denied = 0;
        owner  = 0;
        due_data = '0;
        forever begin
            @(negedge Clk_100MHz);
            if (!Reset_n) begin
                check("rst IF_gnt", IF_gnt, 0);
                check("rst MEM_gnt", MEM_gnt, 0);
                check("rst IF_rvalid", IF_rvalid, 0);
                check("rst MEM_rvalid", MEM_rvalid, 0);
                check("rst IF_rdata", IF_rdata, 0);
                check("rst MEM_rdata", MEM_rdata, 0);
                check("rst RAM_en", RAM_en, 0);
                check("rst RAM_we", RAM_we, 0);
                check("rst RAM_addr", RAM_addr, 0);
                check("rst RAM_wdata", RAM_wdata, 0);
                denied = 0;
                owner  = 0;
            end else begin
                e_if  = IF_req && !Flush && (!MEM_req || denied == MAX_STARVE);
                e_mem = MEM_req && !e_if;
                check("IF_gnt", IF_gnt, e_if);
                check("MEM_gnt", MEM_gnt, e_mem);
                check("RAM_en", RAM_en, e_if || e_mem);
                widx = e_if ? int'((IF_addr >> 2) % DEPTH)
                            : (e_mem ? int'((MEM_addr >> 2) % DEPTH) : 0);
                check("RAM_addr", RAM_addr, widx);
                check("RAM_we", RAM_we, (e_mem && MEM_we) ? MEM_be : 4'b0000);
                check("RAM_wdata", RAM_wdata, e_mem ? MEM_wdata : 32'h0);
                check("IF_rvalid", IF_rvalid, owner == 1 && !Flush);
                check("IF_rdata", IF_rdata, (owner == 1 && !Flush) ? due_data : 32'h0);
                check("MEM_rvalid", MEM_rvalid, owner == 2);
                check("MEM_rdata", MEM_rdata, owner == 2 ? due_data : 32'h0);

                owner = 0;
                if (e_if) begin
                    owner    = 1;
                    due_data = shadow[widx];
                end else if (e_mem && !MEM_we) begin
                    owner    = 2;
                    due_data = shadow[widx];
                end else if (e_mem) begin
                    for (int b = 0; b < 4; b++)
                        if (MEM_be[b]) shadow[widx][8*b +: 8] = MEM_wdata[8*b +: 8];
                end
                denied = (IF_req && !Flush && !e_if) ? denied + 1 : 0;
            end
        end
    end

    task automatic step();
        @(posedge Clk_100MHz);
        #1;
    endtask

    task automatic drive(bit ifr, logic [31:0] ifa, bit mr, bit we, logic [3:0] be,
                         logic [31:0] ma, logic [31:0] wd, bit fl);
        IF_req = ifr; IF_addr = ifa; MEM_req = mr; MEM_we = we; MEM_be = be;
        MEM_addr = ma; MEM_wdata = wd; Flush = fl;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        Reset_n = 1'b0;
        drive(1, 32'h10, 1, 0, 0, 32'h100, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step(); #2;
            check("hold rst IF_gnt", IF_gnt, 0);
            check("hold rst MEM_gnt", MEM_gnt, 0);
            check("hold rst RAM_en", RAM_en, 0);
        end

        // Release and fetch word 4.
        step(); Reset_n = 1'b1; drive(1, 32'h10, 0, 0, 0, 0, 0, 0); #2;
        check("first IF_gnt", IF_gnt, 1);
        check("first RAM_addr", RAM_addr, 12'h004);
        step(); idle(); #2;
        check("first IF_rvalid", IF_rvalid, 1);
        check("first IF_rdata", IF_rdata, 32'hC0DE0004);

        // Contention: MEM wins by default.
        step(); drive(1, 32'h40, 1, 0, 0, 32'h100, 0, 0); #2;
        check("cont MEM_gnt", MEM_gnt, 1);
        check("cont IF_gnt", IF_gnt, 0);
        check("cont RAM_addr", RAM_addr, 12'h040);
        step(); idle(); #2;
        check("cont MEM_rvalid", MEM_rvalid, 1);
        check("cont IF_rvalid", IF_rvalid, 0);
        check("cont MEM_rdata", MEM_rdata, 32'hC0DE0040);

        // Starvation relief: IF wins every fifth cycle under continuous contention.
        for (int k = 0; k < 10; k++) begin
            step(); drive(1, 32'h80, 1, 0, 0, 32'h200 + 32'(4 * k), 0, 0); #2;
            check("starve IF_gnt", IF_gnt, (k % 5) == 4);
            check("starve MEM_gnt", MEM_gnt, (k % 5) != 4);
        end

        // Partial store then load back.
        step(); drive(0, 0, 1, 1, 4'b0011, 32'h8, 32'hDEADBEEF, 0); #2;
        check("store RAM_we", RAM_we, 4'b0011);
        check("store RAM_addr", RAM_addr, 12'h002);
        check("store RAM_wdata", RAM_wdata, 32'hDEADBEEF);
        step(); drive(0, 0, 1, 0, 0, 32'h8, 0, 0); #2;
        check("store no MEM_rvalid", MEM_rvalid, 0);
        step(); idle(); #2;
        check("load after store", MEM_rdata, 32'hC0DEBEEF);

        // Flush kills the in-flight fetch and blocks the grant.
        step(); drive(1, 32'h20, 0, 0, 0, 0, 0, 0); #2;
        check("flush pre IF_gnt", IF_gnt, 1);
        step(); drive(1, 32'h24, 0, 0, 0, 0, 0, 1); #2;
        check("flush IF_rvalid", IF_rvalid, 0);
        check("flush IF_gnt", IF_gnt, 0);
        check("flush IF_rdata", IF_rdata, 0);
        step(); drive(1, 32'h24, 0, 0, 0, 0, 0, 0); #2;
        check("post flush IF_gnt", IF_gnt, 1);
        step(); idle(); #2;
        check("post flush IF_rdata", IF_rdata, 32'hC0DE0009);

        // Asynchronous reset in the middle of an access.
        step(); drive(1, 32'h30, 0, 0, 0, 0, 0, 0); #1;
        check("mid rst pre IF_gnt", IF_gnt, 1);
        Reset_n = 1'b0; #1;
        check("mid rst IF_gnt", IF_gnt, 0);
        check("mid rst RAM_en", RAM_en, 0);
        step(); Reset_n = 1'b1; idle(); #2;
        check("after rst IF_rvalid", IF_rvalid, 0);
        step(); #2;
        check("after rst IF_rvalid 2", IF_rvalid, 0);

        // Randomized traffic; the word index is kept small so reads hit earlier stores.
        for (int k = 0; k < 3000; k++) begin
            step();
            if (!Reset_n) Reset_n = 1'b1;
            drive($urandom_range(0, 3) != 0, $urandom() & 32'hFFFF_C0FF,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0,
                  4'($urandom()), $urandom() & 32'hFFFF_C0FF, $urandom(),
                  $urandom_range(0, 9) == 0);
            if ($urandom_range(0, 299) == 0) begin
                #1;
                Reset_n = 1'b0;
            end
        end
        step(); Reset_n = 1'b1; idle();
        step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
